// File: rtl/updn_cntr_pkg.sv
// updn_cntr_pkg: shared mode type and width helpers for the
// parametrised up/down counter (updn_cntr_mod, updn_nxt_calc).
package updn_cntr_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_t;

  localparam int CNT_EXT_W = 1;

  function automatic int cnt_iw(input int width);
    return width + CNT_EXT_W;
  endfunction

  function automatic int cnt_max(input int modulus);
    return modulus - 1;
  endfunction

  function automatic cnt_mode_t mode_dec(input logic sat);
    return sat ? CNT_SAT : CNT_WRAP;
  endfunction

endpackage

// File: rtl/updn_nxt_calc.sv
// updn_nxt_calc: combinational next count and overflow/underflow
// events for one enabled step of the modulo-MOD counter.
module updn_nxt_calc
  import updn_cntr_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MOD    = 10,
  parameter int STEP_W = 2
) (
  input  logic [WIDTH-1:0]  cnt_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              up_i,
  input  cnt_mode_t         mode_i,
  output logic [WIDTH-1:0]  nxt_o,
  output logic              ovf_o,
  output logic              unf_o
);

  localparam int IW = cnt_iw(WIDTH);
  localparam logic [IW-1:0] MOD_X = IW'(MOD);
  localparam logic [IW-1:0] MAX_X = IW'(cnt_max(MOD));

  logic [IW-1:0] cnt_x;
  logic [IW-1:0] step_x;
  logic [IW-1:0] sum_x;
  logic [IW-1:0] wrp_x;
  logic [IW-1:0] nxt_x;

  assign cnt_x  = {1'b0, cnt_i};
  assign step_x = {{(IW-STEP_W){1'b0}}, step_i};
  assign sum_x  = cnt_x + step_x;
  // Adding MOD before subtracting keeps the down-wrap non-negative.
  assign wrp_x  = cnt_x + MOD_X - step_x;

  always_comb begin
    nxt_x = cnt_x;
    ovf_o = 1'b0;
    unf_o = 1'b0;
    if (up_i) begin
      if (sum_x > MAX_X) begin
        ovf_o = 1'b1;
        nxt_x = (mode_i == CNT_SAT) ? MAX_X : sum_x - MOD_X;
      end else begin
        nxt_x = sum_x;
      end
    end else begin
      if (step_x > cnt_x) begin
        unf_o = 1'b1;
        nxt_x = (mode_i == CNT_SAT) ? '0 : wrp_x;
      end else begin
        nxt_x = cnt_x - step_x;
      end
    end
  end

  assign nxt_o = WIDTH'(nxt_x);

endmodule

// File: rtl/updn_cntr_mod.sv
// updn_cntr_mod: modulo-MOD up/down counter with step, load, wrap/sat
// and registered ovf/unf pulses; UPDN_STS_STICKY_EN adds sticky status.
module updn_cntr_mod
  import updn_cntr_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MOD    = 10,
  parameter int STEP_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              up_dwn_n,
  input  logic [STEP_W-1:0] step,
  input  logic              sat,
  input  logic              ld,
  input  logic [WIDTH-1:0]  ld_val,
  output logic [WIDTH-1:0]  cnt,
  output logic              ovf,
  output logic              unf,
  output logic              at_max,
  output logic              at_min
`ifdef UPDN_STS_STICKY_EN
  ,
  input  logic              clr_sts,
  output logic              ovf_sts,
  output logic              unf_sts
`endif
);

  localparam int IW = cnt_iw(WIDTH);
  localparam logic [IW-1:0]    MOD_X = IW'(MOD);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(cnt_max(MOD));

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] nxt_cnt;
  logic             ovf_ev;
  logic             unf_ev;
  logic [WIDTH-1:0] ld_cl;
  cnt_mode_t        mode;

  assign mode  = mode_dec(sat);
  assign ld_cl = ({1'b0, ld_val} < MOD_X) ? ld_val : MAX_W;

  updn_nxt_calc #(
    .WIDTH  (WIDTH),
    .MOD    (MOD),
    .STEP_W (STEP_W)
  ) u_nxt (
    .cnt_i  (cnt_q),
    .step_i (step),
    .up_i   (up_dwn_n),
    .mode_i (mode),
    .nxt_o  (nxt_cnt),
    .ovf_o  (ovf_ev),
    .unf_o  (unf_ev)
  );

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    unique case (1'b1)
      !rst_n: begin
        cnt_d = '0;
      end
      rst_n && ld: begin
        cnt_d = ld_cl;
      end
      rst_n && !ld && en: begin
        cnt_d = nxt_cnt;
        ovf_d = ovf_ev;
        unf_d = unf_ev;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
    ovf_q <= ovf_d;
    unf_q <= unf_d;
  end

  assign cnt    = cnt_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
  assign at_max = (cnt_q == MAX_W);
  assign at_min = (cnt_q == '0);

`ifdef UPDN_STS_STICKY_EN
  logic ovf_sts_q, ovf_sts_d;
  logic unf_sts_q, unf_sts_d;

  // A new event outranks a same-cycle clear.
  always_comb begin
    ovf_sts_d = ovf_d | (ovf_sts_q & ~clr_sts);
    unf_sts_d = unf_d | (unf_sts_q & ~clr_sts);
    if (!rst_n) begin
      ovf_sts_d = 1'b0;
      unf_sts_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    ovf_sts_q <= ovf_sts_d;
    unf_sts_q <= unf_sts_d;
  end

  assign ovf_sts = ovf_sts_q;
  assign unf_sts = unf_sts_q;
`endif

endmodule

// File: tb/tb_updn_cntr_mod.sv
// tb_updn_cntr_mod: scoreboard bench for updn_cntr_mod, directed
// scenarios plus random traffic against an integer reference model.
module tb_updn_cntr_mod;

  localparam int WIDTH  = 4;
  localparam int MOD    = 10;
  localparam int STEP_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              up_dwn_n = 1'b1;
  logic [STEP_W-1:0] step = '0;
  logic              sat = 1'b0;
  logic              ld = 1'b0;
  logic [WIDTH-1:0]  ld_val = '0;
  logic [WIDTH-1:0]  cnt;
  logic              ovf, unf, at_max, at_min;
  logic              clr_sts = 1'b0;
`ifdef UPDN_STS_STICKY_EN
  logic              ovf_sts, unf_sts;
`endif

  updn_cntr_mod #(
    .WIDTH  (WIDTH),
    .MOD    (MOD),
    .STEP_W (STEP_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dwn_n (up_dwn_n),
    .step     (step),
    .sat      (sat),
    .ld       (ld),
    .ld_val   (ld_val),
    .cnt      (cnt),
    .ovf      (ovf),
    .unf      (unf),
    .at_max   (at_max),
    .at_min   (at_min)
`ifdef UPDN_STS_STICKY_EN
    ,
    .clr_sts  (clr_sts),
    .ovf_sts  (ovf_sts),
    .unf_sts  (unf_sts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    cnt;
    bit    ovf;
    bit    unf;
    bit    os;
    bit    us;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  int m_cnt = 0;
  bit m_os = 0;
  bit m_us = 0;

  function automatic void chk(string nm, int act, int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endfunction

  // Reference model: plain integer arithmetic over the range 0..MOD-1.
  task automatic drive(input bit r, input bit l, input int lv,
                       input bit e, input bit u, input int st,
                       input bit s, input bit c, input string tag);
    exp_t x;
    int   t;
    bit   o, n;
    rst_n = r; ld = l; ld_val = lv[WIDTH-1:0]; en = e;
    up_dwn_n = u; step = st[STEP_W-1:0]; sat = s; clr_sts = c;
    o = 0; n = 0;
    if (!r) m_cnt = 0;
    else if (l) m_cnt = (lv < MOD) ? lv : MOD - 1;
    else if (e) begin
      if (u) begin
        t = m_cnt + st;
        o = (t >= MOD);
        m_cnt = !o ? t : (s ? MOD - 1 : t - MOD);
      end else begin
        t = m_cnt - st;
        n = (t < 0);
        m_cnt = !n ? t : (s ? 0 : t + MOD);
      end
    end
    m_os = r && (o || (m_os && !c));
    m_us = r && (n || (m_us && !c));
    x.tag = tag; x.cnt = m_cnt; x.ovf = o; x.unf = n;
    x.os = m_os; x.us = m_us;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk({x.tag, ".cnt"}, int'(cnt), x.cnt);
        chk({x.tag, ".ovf"}, int'(ovf), int'(x.ovf));
        chk({x.tag, ".unf"}, int'(unf), int'(x.unf));
        chk({x.tag, ".at_max"}, int'(at_max), int'(x.cnt == MOD - 1));
        chk({x.tag, ".at_min"}, int'(at_min), int'(x.cnt == 0));
`ifdef UPDN_STS_STICKY_EN
        chk({x.tag, ".ovf_sts"}, int'(ovf_sts), int'(x.os));
        chk({x.tag, ".unf_sts"}, int'(unf_sts), int'(x.us));
`endif
      end
    end
  end

  initial begin
    // reset overrides ld/en
    drive(0, 1, 7, 1, 1, 1, 0, 0, "rst");
    drive(0, 1, 7, 1, 1, 1, 0, 0, "rst");
    drive(1, 0, 0, 0, 1, 1, 0, 0, "rst_rel");
    // wrap up
    drive(1, 1, 8, 0, 1, 1, 0, 0, "ld8");
    repeat (3) drive(1, 0, 0, 1, 1, 1, 0, 0, "wrap_up");
    // wrap down with step
    drive(1, 1, 1, 0, 0, 3, 0, 0, "ld1");
    repeat (2) drive(1, 0, 0, 1, 0, 3, 0, 0, "wrap_dn");
    // saturate up and down
    drive(1, 1, 8, 0, 1, 3, 1, 0, "ld8s");
    repeat (2) drive(1, 0, 0, 1, 1, 3, 1, 0, "sat_up");
    drive(1, 1, 1, 0, 0, 3, 1, 0, "ld1s");
    repeat (2) drive(1, 0, 0, 1, 0, 3, 1, 0, "sat_dn");
    // load clamp beats en, then gated counting
    drive(1, 1, 15, 1, 1, 3, 0, 0, "ld_clamp");
    for (int i = 0; i < 6; i++)
      drive(1, 0, 0, i % 2, 1, 1, 0, 0, "en_toggle");
    drive(1, 0, 0, 1, 1, 0, 0, 0, "step0");
    // sticky status: set, hold, clear-vs-set, clear
    drive(1, 1, 0, 0, 0, 1, 0, 0, "sts_ld0");
    drive(1, 0, 0, 1, 0, 1, 0, 0, "sts_unf");
    repeat (5) drive(1, 0, 0, 0, 0, 1, 0, 0, "sts_hold");
    drive(1, 1, 0, 0, 0, 1, 0, 0, "sts_ld0b");
    drive(1, 0, 0, 1, 0, 1, 0, 1, "sts_clr_set");
    drive(1, 0, 0, 0, 0, 1, 0, 1, "sts_clr");
    drive(1, 0, 0, 0, 0, 1, 0, 0, "sts_idle");
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(49) != 0,
            $urandom_range(7) == 0,
            int'($urandom_range(15)),
            $urandom_range(3) != 0,
            $urandom_range(1) == 1,
            int'($urandom_range(3)),
            $urandom_range(1) == 1,
            $urandom_range(5) == 0,
            "rand");
    end
    @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/updn_cntr_mod.md
Name: updn_cntr_mod

Overview:
- Parametrised successor to the team's basic enabled up/down counter.
- Generalises width and modulus, adds variable step, parallel load, wrap/saturate mode and registered overflow/underflow pulses.
- Used as the general-purpose sequencing/index counter in datapath control, e.g. filter tap index and sample counters.

Parameters:
- WIDTH, 4, counter width in bits.
- MOD, 10, count modulus; legal range 0..MOD-1. Constraint: 2 <= MOD <= 2**WIDTH.
- STEP_W, 2, width of step input. Constraint: 2**STEP_W - 1 < MOD.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  count enable.
- up_dwn_n  in  1  direction: 1 = up, 0 = down.
- step  in  STEP_W  increment/decrement amount; 0 = hold.
- sat  in  1  mode: 1 = saturate, 0 = wrap (modulo MOD).
- ld  in  1  parallel load strobe.
- ld_val  in  WIDTH  load value.
- cnt  out  WIDTH  current count, registered.
- ovf  out  1  registered 1-cycle pulse, up-count crossed MOD-1.
- unf  out  1  registered 1-cycle pulse, down-count crossed 0.
- at_max  out  1  combinational, cnt == MOD-1.
- at_min  out  1  combinational, cnt == 0.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clk, rst_n).
  - On a posedge with rst_n=0: cnt=0, ovf=0, unf=0. Status flags are cleared too when compiled in.
- Priority each posedge: rst_n low > ld > en > hold.
- Load:
  - cnt <= ld_val if ld_val < MOD, else MOD-1 (clamped).
  - ovf/unf = 0 on a load cycle; en is ignored that cycle.
- Count (en=1, ld=0):
  - Arithmetic in WIDTH+1 bits, no intermediate truncation.
  - Up: s = cnt + step.
    - If s <= MOD-1: cnt <= s.
    - Else wrap: cnt <= s - MOD. Saturate: cnt <= MOD-1.
    - ovf <= 1 in both modes.
  - Down: if step <= cnt, cnt <= cnt - step.
    - Else wrap: cnt <= cnt + MOD - step. Saturate: cnt <= 0.
    - unf <= 1 in both modes.
  - step=0: cnt unchanged, no pulse.
- Saturate mode at a limit: cnt holds, and ovf/unf still pulses on each enabled attempt to pass the limit.
- en=0: cnt holds; ovf=unf=0.
- Latency:
  - cnt updates on the same edge the controls are sampled.
  - ovf/unf are high for exactly the cycle following that edge, aligned with the new cnt.
- at_max/at_min track cnt combinationally, with no extra latency.
- Mode or direction changes take effect on the next enabled edge. There is no pipeline, so there is no stale state.
- Reset asserted mid-count overrides ld/en that cycle.

Optional Feature:
- Macro: UPDN_STS_STICKY_EN.
- Defined:
  - Adds ports clr_sts (in, 1), ovf_sts (out, 1) and unf_sts (out, 1).
  - ovf_sts/unf_sts are set by the ovf/unf event and held until clr_sts=1 or reset.
  - If clr_sts coincides with a new event, the set wins.
- Undefined: the ports and registers are absent; the remaining behaviour is identical.

Decomposition:
- Package updn_cntr_pkg:
  - typedef enum {CNT_WRAP, CNT_SAT} cnt_mode_t, decoded from sat.
  - localparam helpers for the MOD-1 constant and the WIDTH+1 internal width.
- Sub-module updn_nxt_calc: purely combinational next-count plus ovf/unf-event computation. The top level keeps the registers and the priority logic.

Test Plan:
- Reset/priority: hold rst_n=0 with ld=1, en=1 for 2 cycles -> cnt=0, ovf=unf=0. Release with en=0 -> cnt stays 0.
- Wrap up: cnt=8, up, step=1, sat=0, en for 3 cycles -> cnt 9, 0, 1. ovf high only in the cycle cnt=0.
- Wrap down with step: ld_val=1, down, step=3, sat=0, one enable -> cnt=8, unf pulse 1 cycle. Next enable -> cnt=5, unf=0.
- Saturate: ld_val=8, up, step=3, sat=1, 2 enables -> cnt 9, 9. ovf pulses both cycles; at_max=1.
- Load clamp/priority: ld=1, ld_val=15, en=1 -> cnt=9, ovf=0. Then en toggled 0/1 alternately with step=1, up -> cnt advances only on enabled edges.
- With UPDN_STS_STICKY_EN: trigger unf -> unf_sts=1 held 5 idle cycles. clr_sts=1 together with a new unf event -> unf_sts stays 1. clr_sts alone -> unf_sts=0.
